// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative signed WIDTH x WIDTH multiply / WIDTH / WIDTH divide
// for the EX stage. One shift-add or restoring subtract-shift step per cycle,
// followed by a single sign-correction cycle. Holds the pipeline via stall
// while an operation is in flight.
//
// Optional build macro: MULDIV_DIV0_EARLY_EXIT_EN
//   When defined, a divide by zero is resolved in the accept cycle and the
//   unit jumps straight to DONE (done in cycle 1). When undefined, a divide
//   by zero runs the full iterative latency and the results are forced in FIX.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start; results hold their last value
// RUN    | one iteration per cycle; counter counts WIDTH-1 down to 0
// FIX    | sign correction / divide-by-zero forcing into result regs
// DONE   | done pulse; results valid; a new start is accepted here
module ex_muldiv_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic             accept;
    logic             b_zero;
    logic             early_div0;

    logic             op_r;
    logic             sign_a;
    logic             sign_b;
    logic             div0_r;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] p_hi;
    logic [WIDTH-1:0] p_lo;
    logic [CW-1:0]    count;

    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   a_raw;

    assign b_zero = (operand_b == '0);
    assign abs_a  = operand_a[WIDTH-1] ? -operand_a : operand_a;
    assign abs_b  = operand_b[WIDTH-1] ? -operand_b : operand_b;

`ifdef MULDIV_DIV0_EARLY_EXIT_EN
    assign early_div0 = accept & op & b_zero;
`else
    assign early_div0 = 1'b0;
`endif

    // Iteration datapath: p_lo starts as |a|; for multiply it is the shifting
    // multiplier and low product half, for divide it shifts dividend bits out
    // and quotient bits in. p_hi is the high product half or the remainder.
    assign mul_sum   = {1'b0, p_hi} + (p_lo[0] ? {1'b0, mag_b} : {(WIDTH+1){1'b0}});
    assign div_shift = {p_hi, p_lo[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, mag_b});
    assign div_diff  = div_shift - {1'b0, mag_b};

    // Sign correction; remainder follows the dividend, quotient truncates to zero.
    assign prod_fix = (sign_a ^ sign_b) ? -{p_hi, p_lo} : {p_hi, p_lo};
    assign quot_fix = (sign_a ^ sign_b) ? -p_lo : p_lo;
    assign rem_fix  = sign_a ? -p_hi : p_hi;
    assign a_raw    = sign_a ? -mag_a : mag_a;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nx = state;
        busy     = (state == S_RUN) || (state == S_FIX);
        done     = (state == S_DONE);
        accept   = start & ~busy;
        stall    = (start & ~busy) | busy;
        case (state)
            S_IDLE: begin
                if (start) state_nx = early_div0 ? S_DONE : S_RUN;
            end
            S_RUN: begin
                if (count == '0) state_nx = S_FIX;
            end
            S_FIX: begin
                state_nx = S_DONE;
            end
            S_DONE: begin
                if (start) state_nx = early_div0 ? S_DONE : S_RUN;
                else       state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Operand capture, iteration steps and result registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            op_r        <= 1'b0;
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
            div0_r      <= 1'b0;
            mag_a       <= '0;
            mag_b       <= '0;
            p_hi        <= '0;
            p_lo        <= '0;
            count       <= '0;
            result_lo   <= '0;
            result_hi   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            op_r        <= op;
            sign_a      <= operand_a[WIDTH-1];
            sign_b      <= operand_b[WIDTH-1];
            div0_r      <= op & b_zero;
            mag_a       <= abs_a;
            mag_b       <= abs_b;
            p_hi        <= '0;
            p_lo        <= abs_a;
            count       <= CW'(WIDTH - 1);
            div_by_zero <= 1'b0;
`ifdef MULDIV_DIV0_EARLY_EXIT_EN
            if (early_div0) begin
                result_lo   <= '1;
                result_hi   <= operand_a;
                div_by_zero <= 1'b1;
            end
`endif
        end else if (state == S_RUN) begin
            if (count != '0) count <= count - CW'(1);
            if (!op_r) begin
                p_hi <= mul_sum[WIDTH:1];
                p_lo <= {mul_sum[0], p_lo[WIDTH-1:1]};
            end else begin
                p_hi <= div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                p_lo <= {p_lo[WIDTH-2:0], div_ge};
            end
        end else if (state == S_FIX) begin
            if (!op_r) begin
                result_lo <= prod_fix[WIDTH-1:0];
                result_hi <= prod_fix[2*WIDTH-1:WIDTH];
            end else if (div0_r) begin
                result_lo   <= '1;
                result_hi   <= a_raw;
                div_by_zero <= 1'b1;
            end else begin
                result_lo <= quot_fix;
                result_hi <= rem_fix;
            end
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit. Stimulus pushes expected results and
// the expected done cycle into a scoreboard; an independent negedge monitor
// pops and compares whenever done is presented.
module tb_ex_muldiv_unit;

    localparam int W   = 16;
    localparam int LAT = W + 2;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic         op;
    logic [W-1:0] operand_a;
    logic [W-1:0] operand_b;
    logic         busy;
    logic         stall;
    logic         done;
    logic [W-1:0] result_lo;
    logic [W-1:0] result_hi;
    logic         div_by_zero;

    ex_muldiv_unit #(.WIDTH(W)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .busy        (busy),
        .stall       (stall),
        .done        (done),
        .result_lo   (result_lo),
        .result_hi   (result_hi),
        .div_by_zero (div_by_zero)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        string        name;
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         dz;
        int           due;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: compare every presented result against the scoreboard head.
    always @(negedge clock) begin
        exp_t e;
        if (done === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", done, 0);
            end else begin
                e = sb_q.pop_front();
                check({e.name, "_lo"}, result_lo, e.lo);
                check({e.name, "_hi"}, result_hi, e.hi);
                check({e.name, "_dz"}, div_by_zero, e.dz);
                check({e.name, "_done_cycle"}, cyc, e.due);
            end
        end
    end

    task automatic sync();
        @(posedge clock);
        #1;
    endtask

    function automatic int lat_of(input logic o, input logic [W-1:0] b);
`ifdef MULDIV_DIV0_EARLY_EXIT_EN
        if (o && b == '0) return 1;
`endif
        return LAT;
    endfunction

    task automatic push_exp(input string name, input logic [W-1:0] lo, input logic [W-1:0] hi,
                            input logic dz, input int due);
        exp_t e;
        e.name = name; e.lo = lo; e.hi = hi; e.dz = dz; e.due = due;
        sb_q.push_back(e);
    endtask

    // Issue one op; called just after a rising edge (cycle 0 = this cycle).
    task automatic issue(input string name, input logic o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] lo,
                         input logic [W-1:0] hi, input logic dz, input bit do_push);
        if (do_push) push_exp(name, lo, hi, dz, cyc + lat_of(o, b));
        start = 1'b1; op = o; operand_a = a; operand_b = b;
        #1;
        check({name, "_stall_accept"}, stall, 1);
        sync();
        start = 1'b0; operand_a = 'x; operand_b = 'x;
    endtask

    // Waits for done (bounded), checking stall stays high until then and is low at done.
    task automatic wait_done(input string name);
        bit seen = 0;
        int stall_low = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clock);
            if (done === 1'b1) begin
                seen = 1;
                break;
            end
            if (stall !== 1'b1) stall_low++;
        end
        check({name, "_done_seen"}, seen, 1);
        check({name, "_stall_run_low_cycles"}, stall_low, 0);
        if (seen) check({name, "_stall_at_done"}, stall, 0);
    endtask

    task automatic run_op(input string name, input logic o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] lo,
                          input logic [W-1:0] hi, input logic dz);
        issue(name, o, a, b, lo, hi, dz, 1);
        wait_done(name);
        sync();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 1'b0; operand_a = '0; operand_b = '0;
        repeat (3) sync();
        reset = 1'b0;
        @(negedge clock);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_stall", stall, 0);
        check("rst_lo", result_lo, 0);
        check("rst_hi", result_hi, 0);
        check("rst_dz", div_by_zero, 0);
        sync();

        //      name            op    a         b         lo        hi        dz
        run_op("mul_7_m3",     1'b0, 16'h0007, 16'hFFFD, 16'hFFEB, 16'hFFFF, 1'b0);
        run_op("div_m7_2",     1'b1, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0);
        run_op("div_100_0",    1'b1, 16'h0064, 16'h0000, 16'hFFFF, 16'h0064, 1'b1);
        run_op("div_min_m1",   1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0);
        run_op("mul_min_min",  1'b0, 16'h8000, 16'h8000, 16'h0000, 16'h4000, 1'b0);
        run_op("div_max_min",  1'b1, 16'h7FFF, 16'h8000, 16'h0000, 16'h7FFF, 1'b0);
        run_op("div_7_m2",     1'b1, 16'h0007, 16'hFFFE, 16'hFFFD, 16'h0001, 1'b0);
        run_op("div_m100_0",   1'b1, 16'hFF9C, 16'h0000, 16'hFFFF, 16'hFF9C, 1'b1);
        run_op("mul_max_max",  1'b0, 16'h7FFF, 16'h7FFF, 16'h0001, 16'h3FFF, 1'b0);

        // Start while busy must be ignored.
        issue("mul_3_4_ign", 1'b0, 16'h0003, 16'h0004, 16'h000C, 16'h0000, 1'b0, 1);
        repeat (4) sync();
        start = 1'b1; op = 1'b1; operand_a = 16'h0051; operand_b = 16'h0009;
        #1;
        check("ign_busy_at_cycle5", busy, 1);
        sync();
        start = 1'b0;
        wait_done("mul_3_4_ign");
        sync();

        // Reset mid-operation: abandoned, no done, outputs cleared.
        issue("mul_rst", 1'b0, 16'h0006, 16'h0007, 16'h0000, 16'h0000, 1'b0, 0);
        repeat (4) sync();
        reset = 1'b1;
        sync();
        reset = 1'b0;
        @(negedge clock);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_lo", result_lo, 0);
        check("midrst_hi", result_hi, 0);
        check("midrst_dz", div_by_zero, 0);
        repeat (25) sync();

        // Back-to-back: second start presented in the DONE cycle of the first.
        issue("mul_2_2", 1'b0, 16'h0002, 16'h0002, 16'h0004, 16'h0000, 1'b0, 1);
        wait_done("mul_2_2");
        push_exp("mul_5_5_b2b", 16'h0019, 16'h0000, 1'b0, cyc + LAT);
        start = 1'b1; op = 1'b0; operand_a = 16'h0005; operand_b = 16'h0005;
        sync();
        start = 1'b0;
        wait_done("mul_5_5_b2b");
        repeat (3) sync();

        check("scoreboard_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
